// File: rtl/csr_pkg.sv
// Shared CSR definitions for the machine-mode register file.
// Addresses, write-slot bundle, privilege encoding and mstatus fields.
package csr_pkg;

  localparam int CSR_XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam logic [CSR_XLEN-1:0] MISA_VALUE =
    64'h8000_0000_0000_0100;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_M = 2'b11
  } priv_e;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } redir_e;

  typedef struct packed {
    logic [11:0]         addr;
    logic [CSR_XLEN-1:0] data;
    logic                we;
  } csr_op_t;

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with increment enable and write override.
// A write in the same cycle wins over the increment.
module csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (we_i)
      cnt_d = wdata_i;
    else if (inc_i)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file at commit: slot writes, counters,
// ECALL/MRET redirect and privilege tracking.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int NUM_OPS = 3,
  parameter int XLEN    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    commit_valid,
  input  csr_op_t [NUM_OPS-1:0]   csr_ops,
  input  logic                    is_ecall,
  input  logic                    is_mret,
  input  logic [11:0]             raddr,
  output logic [XLEN-1:0]         rdata,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic [1:0]              priv_mode
);

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  logic            cyc_we, ret_we;
  logic [XLEN-1:0] cyc_wd, ret_wd;
  logic [XLEN-1:0] mcycle, minstret;

  redir_e          state_q;
  logic            rv_q;
  logic [XLEN-1:0] rpc_q;
  logic [1:0]      priv_q;

  logic take_trap, take_ret;

  assign take_trap = commit_valid && is_ecall;
  assign take_ret  = commit_valid && is_mret && !is_ecall;

  // Later slots overwrite earlier ones on the same address.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    cyc_we     = 1'b0;
    cyc_wd     = '0;
    ret_we     = 1'b0;
    ret_wd     = '0;
    if (commit_valid) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (csr_ops[i].we) begin
          case (csr_ops[i].addr)
            CSR_MSTATUS:  mstatus_d  = csr_ops[i].data;
            CSR_MIE:      mie_d      = csr_ops[i].data;
            CSR_MTVEC:    mtvec_d    =
              {csr_ops[i].data[XLEN-1:2], 2'b00};
            CSR_MSCRATCH: mscratch_d = csr_ops[i].data;
            CSR_MEPC:     mepc_d     =
              {csr_ops[i].data[XLEN-1:2], 2'b00};
            CSR_MCAUSE:   mcause_d   = csr_ops[i].data;
            CSR_MTVAL:    mtval_d    = csr_ops[i].data;
            CSR_MCYCLE: begin
              cyc_we = 1'b1;
              cyc_wd = csr_ops[i].data;
            end
            CSR_MINSTRET: begin
              ret_we = 1'b1;
              ret_wd = csr_ops[i].data;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter #(.W(XLEN)) u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (1'b1),
    .we_i    (cyc_we),
    .wdata_i (cyc_wd),
    .count_o (mcycle)
  );

  csr_counter #(.W(XLEN)) u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (commit_valid),
    .we_i    (ret_we),
    .wdata_i (ret_wd),
    .count_o (minstret)
  );

  // MRET restores MPP as it stood before this commit's writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      priv_q  <= PRIV_M;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_REDIRECT: begin
          if (take_trap || take_ret) begin
            state_q <= ST_REDIRECT;
            rv_q    <= 1'b1;
            rpc_q   <= take_trap ? mtvec_d : mepc_d;
          end else begin
            state_q <= ST_IDLE;
            rv_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rv_q    <= 1'b0;
        end
      endcase
      if (take_trap)
        priv_q <= PRIV_M;
      else if (take_ret)
        priv_q <= mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CSR_MSTATUS:  rdata = mstatus_q;
      CSR_MISA:     rdata = MISA_VALUE;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MCYCLE:   rdata = mcycle;
      CSR_MINSTRET: rdata = minstret;
      default:      rdata = '0;
    endcase
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign priv_mode      = priv_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed table,
// reset-mid-redirect sequence and randomized model compare.
module tb_csr_regfile;
  import csr_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            commit_valid;
  csr_op_t [2:0]   csr_ops;
  logic            is_ecall;
  logic            is_mret;
  logic [11:0]     raddr;
  logic [63:0]     rdata;
  logic            redirect_valid;
  logic [63:0]     redirect_pc;
  logic [1:0]      priv_mode;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_regfile #(.NUM_OPS(3), .XLEN(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .commit_valid   (commit_valid),
    .csr_ops        (csr_ops),
    .is_ecall       (is_ecall),
    .is_mret        (is_mret),
    .raddr          (raddr),
    .rdata          (rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .priv_mode      (priv_mode)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: flat CSR array indexed by address.
  logic [63:0] m [4096];
  logic        m_rv;
  logic [63:0] m_pc;
  logic [1:0]  m_priv;

  function automatic bit wr_ok(logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                     12'h342, 12'h343, 12'hB00, 12'hB02};
  endfunction

  function automatic logic [63:0] mread(logic [11:0] a);
    if (a == 12'h301) return 64'h8000_0000_0000_0100;
    if (wr_ok(a)) return m[a];
    return 64'h0;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 4096; i++) m[i] = 64'h0;
    m_rv = 1'b0;
    m_pc = 64'h0;
    m_priv = 2'b11;
  endtask

  task automatic mstep();
    logic [63:0] old_ms;
    logic [63:0] v;
    old_ms = m[12'h300];
    m[12'hB00] = m[12'hB00] + 64'd1;
    m_rv = 1'b0;
    if (commit_valid) begin
      m[12'hB02] = m[12'hB02] + 64'd1;
      for (int s = 0; s < 3; s++) begin
        if (csr_ops[s].we && wr_ok(csr_ops[s].addr)) begin
          v = csr_ops[s].data;
          if (csr_ops[s].addr == 12'h341 || csr_ops[s].addr == 12'h305)
            v[1:0] = 2'b00;
          m[csr_ops[s].addr] = v;
        end
      end
      if (is_ecall) begin
        m_rv = 1'b1;
        m_pc = m[12'h305];
        m_priv = 2'b11;
      end else if (is_mret) begin
        m_rv = 1'b1;
        m_pc = m[12'h341];
        m_priv = old_ms[12:11];
      end
    end
  endtask

  task automatic tick();
    mstep();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    commit_valid = 1'b0;
    is_ecall = 1'b0;
    is_mret = 1'b0;
    csr_ops = '0;
  endtask

  typedef struct {
    logic        cv, ec, mr;
    logic [11:0] a0; logic [63:0] d0; logic w0;
    logic [11:0] a1; logic [63:0] d1; logic w1;
    logic [11:0] a2; logic [63:0] d2; logic w2;
    logic [11:0] ra;
    logic [63:0] er;
    logic        erv;
    logic [63:0] epc;
    logic [1:0]  epriv;
  } vec_t;

  function automatic vec_t mk(
    logic cv, logic ec, logic mr,
    logic [11:0] a0, logic [63:0] d0, logic w0,
    logic [11:0] a1, logic [63:0] d1, logic w1,
    logic [11:0] a2, logic [63:0] d2, logic w2,
    logic [11:0] ra, logic [63:0] er, logic erv,
    logic [63:0] epc, logic [1:0] epriv);
    vec_t t;
    t.cv = cv; t.ec = ec; t.mr = mr;
    t.a0 = a0; t.d0 = d0; t.w0 = w0;
    t.a1 = a1; t.d1 = d1; t.w1 = w1;
    t.a2 = a2; t.d2 = d2; t.w2 = w2;
    t.ra = ra; t.er = er; t.erv = erv;
    t.epc = epc; t.epriv = epriv;
    return t;
  endfunction

  vec_t tbl [17];

  localparam logic [11:0] ADDRS [12] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'h7C0
  };

  function automatic logic [11:0] pick();
    return ADDRS[$urandom_range(0, 11)];
  endfunction

  function automatic logic [63:0] rdat();
    if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 12'hB00, 64'd1, 0, 0, 2'b11);
    tbl[1]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 12'hB00, 64'd2, 0, 0, 2'b11);
    tbl[2]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 12'hB00, 64'd3, 0, 0, 2'b11);
    tbl[3]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 12'hB00, 64'd4, 0, 0, 2'b11);
    tbl[4]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, 12'hB00, 64'd5, 0, 0, 2'b11);
    tbl[5]  = mk(1,0,0, 12'h305,64'h8000_0103,1, 0,0,0, 0,0,0,
                 12'h305, 64'h8000_0100, 0, 0, 2'b11);
    tbl[6]  = mk(1,1,0, 12'h341,64'h8000_0040,1, 0,0,0, 12'h342,64'd11,1,
                 12'h342, 64'd11, 1, 64'h8000_0100, 2'b11);
    tbl[7]  = mk(1,0,0, 12'h300,64'h0,1, 0,0,0, 0,0,0,
                 12'h300, 64'h0, 0, 0, 2'b11);
    tbl[8]  = mk(1,0,1, 12'h300,64'h80,1, 0,0,0, 0,0,0,
                 12'h300, 64'h80, 1, 64'h8000_0040, 2'b00);
    tbl[9]  = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0,
                 12'h341, 64'h8000_0040, 0, 0, 2'b00);
    tbl[10] = mk(1,0,0, 12'h340,64'hAA,1, 12'h340,64'hBB,1, 12'h301,64'h1234,1,
                 12'h340, 64'hBB, 0, 0, 2'b00);
    tbl[11] = mk(0,0,0, 0,0,0, 0,0,0, 0,0,0,
                 12'h301, 64'h8000_0000_0000_0100, 0, 0, 2'b00);
    tbl[12] = mk(1,0,0, 12'hB02,64'hFFFF_FFFF_FFFF_FFFF,1, 0,0,0, 0,0,0,
                 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 2'b00);
    tbl[13] = mk(1,0,0, 0,0,0, 0,0,0, 0,0,0, 12'hB02, 64'h0, 0, 0, 2'b00);
    tbl[14] = mk(1,1,0, 0,0,0, 12'h305,64'h200,1, 0,0,0,
                 12'h344, 64'h0, 1, 64'h200, 2'b11);
    tbl[15] = mk(1,1,1, 12'h341,64'h303,1, 0,0,0, 0,0,0,
                 12'h341, 64'h300, 1, 64'h200, 2'b11);
    tbl[16] = mk(0,0,0, 12'h340,64'h55,1, 0,0,0, 0,0,0,
                 12'h340, 64'hBB, 0, 0, 2'b11);

    idle_in();
    raddr = 12'h301;
    reset = 1'b1;
    mreset();
    #12;
    chk("reset_misa", rdata, 64'h8000_0000_0000_0100);
    raddr = 12'h300;
    #1;
    chk("reset_mstatus", rdata, 64'h0);
    chk("reset_priv", {62'h0, priv_mode}, 64'h3);
    chk("reset_rv", {63'h0, redirect_valid}, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      commit_valid = tbl[i].cv;
      is_ecall = tbl[i].ec;
      is_mret = tbl[i].mr;
      csr_ops[0] = '{tbl[i].a0, tbl[i].d0, tbl[i].w0};
      csr_ops[1] = '{tbl[i].a1, tbl[i].d1, tbl[i].w1};
      csr_ops[2] = '{tbl[i].a2, tbl[i].d2, tbl[i].w2};
      raddr = tbl[i].ra;
      tick();
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].er);
      chk($sformatf("vec%0d_rv", i), {63'h0, redirect_valid},
          {63'h0, tbl[i].erv});
      chk($sformatf("vec%0d_priv", i), {62'h0, priv_mode},
          {62'h0, tbl[i].epriv});
      if (tbl[i].erv)
        chk($sformatf("vec%0d_pc", i), redirect_pc, tbl[i].epc);
    end

    // ECALL, then reset lands while the redirect pulse is high.
    idle_in();
    commit_valid = 1'b1;
    is_ecall = 1'b1;
    csr_ops[0] = '{12'h340, 64'h77, 1'b1};
    raddr = 12'h340;
    tick();
    idle_in();
    chk("pre_reset_rv", {63'h0, redirect_valid}, 64'h1);
    chk("pre_reset_pc", redirect_pc, 64'h200);
    chk("pre_reset_mscratch", rdata, 64'h77);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rv", {63'h0, redirect_valid}, 64'h0);
    chk("async_pc", redirect_pc, 64'h0);
    chk("async_priv", {62'h0, priv_mode}, 64'h3);
    chk("async_mscratch", rdata, 64'h0);
    raddr = 12'h305;
    #1;
    chk("async_mtvec", rdata, 64'h0);
    raddr = 12'hB00;
    #1;
    chk("async_mcycle", rdata, 64'h0);
    raddr = 12'hB02;
    #1;
    chk("async_minstret", rdata, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mreset();

    for (int n = 0; n < 400; n++) begin
      commit_valid = ($urandom_range(0, 3) != 0);
      is_ecall = ($urandom_range(0, 7) == 0);
      is_mret = ($urandom_range(0, 5) == 0);
      for (int s = 0; s < 3; s++)
        csr_ops[s] = '{pick(), rdat(), 1'($urandom_range(0, 1))};
      raddr = pick();
      tick();
      chk($sformatf("rnd%0d_rdata@%h", n, raddr), rdata, mread(raddr));
      chk($sformatf("rnd%0d_rv", n), {63'h0, redirect_valid},
          {63'h0, m_rv});
      chk($sformatf("rnd%0d_priv", n), {62'h0, priv_mode},
          {62'h0, m_priv});
      if (m_rv)
        chk($sformatf("rnd%0d_pc", n), redirect_pc, m_pc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
